// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: default geometry, FSM state
// encoding and the address range helper.
package data_ram_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_RAM_DEPTH = 351;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when a word address refers to an implemented RAM word.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
//   req/we/addr/wdata 0,1 : requests from core (0) and loader/IO (1)
//   ack/err/rdata 0,1     : completion pulse, out-of-range flag, read data
//   ram_address/ram_dataC/ram_writeEnable : to the RAM
//   ram_dataOut           : registered RAM read data
// slave modport is the arbiter's view; master is the surrounding system.
interface data_ram_arbiter_if
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_dataC;
  logic              ram_writeEnable;
  logic [DATA_W-1:0] ram_dataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dataOut,
    output ack0, ack1, err0, err1, rdata0, rdata1,
           ram_address, ram_dataC, ram_writeEnable
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dataOut,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
           ram_address, ram_dataC, ram_writeEnable
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin choice, purely combinational.
//   req   : request bits, [0]=port 0, [1]=port 1
//   last  : port granted most recently
//   grant : one-hot grant, all zero when nothing is requested
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie goes to the port that was not served last time.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one single-port data RAM between the core (port 0) and the
// loader/IO (port 1). Each access takes IDLE -> ISSUE -> DONE: the winning
// request is latched leaving IDLE, the RAM writes on the negedge inside
// ISSUE and returns registered read data at the end of ISSUE, and the
// granted port gets a one-cycle ack in DONE.
//   clock, reset : single clock, asynchronous active-high reset
//   bus          : requester and RAM signals (slave modport)
//   busy         : high whenever the FSM is not in IDLE
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  data_ram_arbiter_if.slave  bus,
  output logic               busy
);

  state_t            state, state_next;
  logic [1:0]        grant;
  logic              last;
  logic              any_req;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;

  // Latched attributes of the access in flight.
  logic              acc_port;
  logic              acc_wr;
  logic              acc_oor;

  logic              done;
  logic              ack0, ack1;
  logic              rd_ok;

  rr_arbiter_2 u_rr (
    .req   ({bus.req1, bus.req0}),
    .last  (last),
    .grant (grant)
  );

  always_comb begin
    any_req   = |grant;
    sel       = grant[1];
    sel_we    = sel ? bus.we1    : bus.we0;
    sel_addr  = sel ? bus.addr1  : bus.addr0;
    sel_wdata = sel ? bus.wdata1 : bus.wdata0;
    sel_ok    = addr_in_range(32'(sel_addr), RAM_DEPTH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write enable is registered so it is exactly the ISSUE cycle; an async
  // reset clears it before the RAM's negedge write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ram_address     <= '0;
      bus.ram_dataC       <= '0;
      bus.ram_writeEnable <= 1'b0;
      last                <= 1'b1;
      acc_port            <= 1'b0;
      acc_wr              <= 1'b0;
      acc_oor             <= 1'b0;
    end else begin
      bus.ram_writeEnable <= 1'b0;
      if (state == IDLE && any_req) begin
        bus.ram_address     <= sel_addr;
        bus.ram_dataC       <= sel_wdata;
        bus.ram_writeEnable <= sel_we & sel_ok;
        last                <= sel;
        acc_port            <= sel;
        acc_wr              <= sel_we;
        acc_oor             <= ~sel_ok;
      end
    end
  end

  always_comb begin
    done  = (state == DONE);
    ack0  = done & ~acc_port;
    ack1  = done &  acc_port;
    rd_ok = ~acc_wr & ~acc_oor;
  end

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.err0   = ack0 & acc_oor;
  assign bus.err1   = ack1 & acc_oor;
  assign bus.rdata0 = (ack0 && rd_ok) ? bus.ram_dataOut : '0;
  assign bus.rdata1 = (ack1 && rd_ok) ? bus.ram_dataOut : '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter with a behavioural RAM.
module tb_data_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  data_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  data_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .RAM_DEPTH(351)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .busy  (busy)
  );

  // RAM model: negedge write, registered read; unwritten words read 5A5A5A5A.
  logic [31:0] mem [int];
  always @(negedge clk)
    if (bus.ram_writeEnable) mem[int'(bus.ram_address)] = bus.ram_dataC;
  always @(posedge clk)
    bus.ram_dataOut <= mem.exists(int'(bus.ram_address)) ?
                       mem[int'(bus.ram_address)] : 32'h5A5A5A5A;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        port, we, err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every ack pops one expected completion.
  task automatic observe();
    exp_t e;
    if (bus.ack0 && bus.ack1) chk("both_ack", 32'd1, 32'd0);
    else if (bus.ack0 || bus.ack1) begin
      if (exp_q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ack_port", bus.ack1, e.port);
        chk("err", bus.ack1 ? bus.err1 : bus.err0, e.err);
        chk("rdata", bus.ack1 ? bus.rdata1 : bus.rdata0, e.rdata);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    observe();
  endtask

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.req1 = v.r1; bus.we0 = v.w0; bus.we1 = v.w1;
    bus.addr0 = v.a0; bus.addr1 = v.a1; bus.wdata0 = v.d0; bus.wdata1 = v.d1;
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    chk("idle_before", busy, 1'b0);
    drive(v);
    e.port = v.port; e.err = v.err; e.rdata = v.rdata;
    exp_q.push_back(e);
    step();  // ISSUE
    chk("early_ack", exp_q.size(), 32'd1);
    chk("busy_issue", busy, 1'b1);
    chk("ram_we_issue", bus.ram_writeEnable, v.we);
    chk("ram_address", bus.ram_address, v.port ? v.a1 : v.a0);
    chk("ram_dataC", bus.ram_dataC, v.port ? v.d1 : v.d0);
    // Request lines other than req change after the grant and must be ignored.
    bus.we0 = 1'b1; bus.we1 = 1'b1;
    bus.addr0 = 10'($urandom_range(0, 350)); bus.addr1 = 10'($urandom_range(0, 350));
    bus.wdata0 = $urandom; bus.wdata1 = $urandom;
    step();  // DONE
    chk("ack_slot", exp_q.size(), 32'd0);
    chk("ram_we_done", bus.ram_writeEnable, 1'b0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();  // IDLE
  endtask

  vec_t tbl [13];
  vec_t v;
  exp_t e;
  int   acks;
  int   last_cyc;

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,10'd5,  10'd0,   32'hDEADBEEF,32'h0,       1'b0,1'b1,1'b0,32'h0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,10'd0,  10'd5,   32'h0,       32'h0,       1'b1,1'b0,1'b0,32'hDEADBEEF};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,10'd10, 10'd11,  32'h11111111,32'h22222222,1'b0,1'b1,1'b0,32'h0};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,10'd10, 10'd10,  32'h0,       32'h0,       1'b1,1'b0,1'b0,32'h11111111};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,10'd0,  10'd350, 32'h0,       32'hCAFEF00D,1'b1,1'b1,1'b0,32'h0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,10'd351,10'd0,   32'h1,       32'h0,       1'b0,1'b0,1'b1,32'h0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,10'd0,  10'd350, 32'h0,       32'h0,       1'b1,1'b0,1'b0,32'hCAFEF00D};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,10'd351,10'd0,   32'h0,       32'h0,       1'b0,1'b0,1'b1,32'h0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,10'd0,  10'd0,   32'h0,       32'h0BADF00D,1'b1,1'b1,1'b0,32'h0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,10'd0,  10'd0,   32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0BADF00D};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b0,10'd350,10'd1023,32'h0,       32'h0,       1'b1,1'b0,1'b1,32'h0};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,10'd350,10'd0,   32'h0,       32'h0,       1'b0,1'b0,1'b0,32'hCAFEF00D};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,10'd0,  10'd5,   32'h0,       32'h0,       1'b1,1'b0,1'b0,32'hDEADBEEF};

    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", bus.ram_writeEnable, 1'b0);
    chk("rst_ack", {bus.ack1, bus.ack0}, 2'b00);
    chk("rst_err", {bus.err1, bus.err0}, 2'b00);
    chk("rst_rdata0", bus.rdata0, 32'h0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_address", bus.ram_address, 10'd0);
    chk("rst_dataC", bus.ram_dataC, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(tbl[i]);

    // Both ports held: grants alternate 0,1,0,1 with acks 3 cycles apart.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'd10;
    for (int k = 0; k < 4; k++) begin
      e.port = k[0]; e.err = 1'b0;
      e.rdata = k[0] ? 32'h11111111 : 32'h0BADF00D;
      exp_q.push_back(e);
    end
    acks = 0; last_cyc = -1;
    for (int c = 0; c < 20 && acks < 4; c++) begin
      step();
      if (bus.ack0 || bus.ack1) begin
        if (last_cyc >= 0) chk("ack_spacing", 32'(c - last_cyc), 32'd3);
        last_cyc = c;
        acks++;
        if (acks == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    chk("held_acks", 32'(acks), 32'd4);
    if (exp_q.size() != 0) begin
      chk("held_leftover", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    step();

    // Reset in the ISSUE cycle of a write cancels it.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'd20; bus.wdata0 = 32'h12345678;
    step();
    chk("pre_rst_we", bus.ram_writeEnable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_issue_we", bus.ram_writeEnable, 1'b0);
    chk("rst_issue_busy", busy, 1'b0);
    chk("rst_issue_ack", {bus.ack1, bus.ack0}, 2'b00);
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("post_rst_busy", busy, 1'b0);
    v = '{1'b1,1'b0,1'b0,1'b0,10'd20,10'd0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h5A5A5A5A};
    run_txn(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have parameter RAM_DEPTH, default 351, number of valid RAM words.
REQ-004 clock  input  1  single clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 req0, req1  input  1 each  access request from core (0) and loader/IO (1).
REQ-007 we0, we1  input  1 each  1=write, 0=read.
REQ-008 addr0, addr1  input  ADDR_W each  word address.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 err0, err1  output  1 each  out-of-range flag, valid with ack.
REQ-012 rdata0, rdata1  output  DATA_W each  read data, valid with ack on reads.
REQ-013 ram_address  output  ADDR_W  to RAM address.
REQ-014 ram_dataC  output  DATA_W  to RAM write data.
REQ-015 ram_writeEnable  output  1  to RAM write enable.
REQ-016 ram_dataOut  input  DATA_W  from RAM registered read output; RAM read clock tied to clock.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, DONE; IDLE->ISSUE when any req high; ISSUE->DONE always; DONE->IDLE always.
REQ-019 In IDLE with a request, the winner's we/addr/wdata SHALL be registered onto ram_* at the posedge leaving IDLE; later changes on the request inputs are ignored until ack.
REQ-020 Arbitration: single request wins; both high -> port not granted last; last-grant pointer resets to port 1 so port 0 wins the first tie.
REQ-021 In ISSUE, ram_writeEnable SHALL be 1 only for an in-range write; the RAM writes on the negedge inside ISSUE and captures read data on the posedge ending ISSUE.
REQ-022 In DONE, ack of the granted port SHALL be 1 for exactly one cycle; rdata of that port = ram_dataOut for reads, 0 for writes; the other port's ack = 0.
REQ-023 Latency: request seen in cycle N -> ack in cycle N+2; max throughput one access per 3 cycles.
REQ-024 Out of range (addr >= RAM_DEPTH): no write enable, ack in the normal slot with err=1, rdata=0.
REQ-025 Requester SHALL hold req until ack; req still high in IDLE after ack is a new request.
REQ-026 ram_writeEnable SHALL be 0 in IDLE and DONE; ram_address/ram_dataC hold last value there.
REQ-027 A port that keeps requesting SHALL be granted within 2 arbitrations (no starvation).

Reset
REQ-028 Reset SHALL immediately force IDLE, ram_writeEnable=0, ack*=0, err*=0, rdata*=0, ram_address=0, ram_dataC=0, busy=0, last-grant=1.
REQ-029 Reset in ISSUE SHALL cancel the access; no ack is produced after release.

Structure
REQ-030 Shared package SHALL hold ADDR_W, DATA_W, RAM_DEPTH defaults and the state encoding (IDLE=0, ISSUE=1, DONE=2).
REQ-031 The 2-way round-robin choice SHALL be the sub-module rr_arbiter_2 (req[1:0], last pointer in -> grant one-hot out, combinational).

Verification
REQ-032 Reset released, req0 write addr 5 data 0xDEADBEEF -> ram_writeEnable=1 in cycle N+1, ack0 in N+2, err0=0.
REQ-033 Then req1 read addr 5 -> ack1 in N+2 with rdata1=0xDEADBEEF, ack0 stays 0.
REQ-034 req0 and req1 held high for 4 accesses -> grant order 0,1,0,1, acks 3 cycles apart.
REQ-035 req0 write addr 351 data 0x1 -> ram_writeEnable never 1, ack0=1 with err0=1; later read of addr 350 is unchanged.
REQ-036 Reset asserted during ISSUE of a write -> ram_writeEnable drops immediately, no ack after release, FSM in IDLE, busy=0.
